// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, register "none" marker, status codes,
// and the per-icode field-presence decode used by fetch.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  function automatic logic has_regids(input logic [3:0] icode);
    return icode inside {IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ};
  endfunction

  function automatic logic has_valc(input logic [3:0] icode);
    return icode inside {IIRMOVQ, IRMMOVQ, IMRMOVQ, IJXX, ICALL};
  endfunction

endpackage

// File: rtl/y86_imem.sv
// Byte-wide instruction store with a clocked load port and a 10-byte combinational read window.
// Bytes beyond the end of storage read as zero; out-of-range loads are dropped rather than aliased.
module y86_imem
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 4096
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load_en,
  input  logic [63:0] load_addr,
  input  logic [7:0]  load_data,
  input  logic [63:0] rd_addr,
  output logic [79:0] rd_bytes
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

  logic [7:0] mem [MEM_BYTES];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
    end else if (load_en && (load_addr < MEM_LIMIT)) begin
      mem[load_addr[AW-1:0]] <= load_data;
    end
  end

  // Each window byte is range-checked on its full 64-bit address so a fetch near the top never wraps into low memory.
  for (genvar k = 0; k < 10; k++) begin : g_rd
    logic [63:0] byte_addr;
    assign byte_addr = rd_addr + 64'(k);
    assign rd_bytes[8*k +: 8] = (byte_addr < MEM_LIMIT) ? mem[byte_addr[AW-1:0]] : 8'h00;
  end

endmodule

// File: rtl/y86_fetch_unit.sv
// Y86-64 fetch stage: instruction memory read, split/align and PC increment, all combinational in f_pc.
// Optional FETCH_TRACE_EN prints f_pc/f_icode/f_ifun on every rising clock; logic is unchanged by it.
module y86_fetch_unit
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 4096
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load_en,
  input  logic [63:0] load_addr,
  input  logic [7:0]  load_data,
  input  logic [63:0] f_pc,
  output logic [3:0]  f_icode,
  output logic [3:0]  f_ifun,
  output logic [3:0]  f_rA,
  output logic [3:0]  f_rB,
  output logic [63:0] f_valC,
  output logic [63:0] f_valP,
  output logic        need_regids,
  output logic        need_valC,
  output logic        instr_valid,
  output logic        imem_error,
  output logic [2:0]  f_stat
);

  localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

  logic [79:0] fetch_bytes;
  logic [7:0]  ibyte;
  logic [71:0] ibytes;
  logic [3:0]  raw_icode;
  logic [63:0] ilen;
  logic [63:0] last_addr;

  y86_imem #(.MEM_BYTES(MEM_BYTES)) u_imem (
    .clock     (clock),
    .reset_n   (reset_n),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .rd_addr   (f_pc),
    .rd_bytes  (fetch_bytes)
  );

  assign ibyte     = fetch_bytes[7:0];
  assign ibytes    = fetch_bytes[79:8];
  assign raw_icode = ibyte[7:4];

  // Length comes from the raw icode so a truncated instruction at the top of memory is still flagged.
  assign need_regids = has_regids(raw_icode);
  assign need_valC   = has_valc(raw_icode);
  assign ilen        = 64'd1 + {63'd0, need_regids} + (need_valC ? 64'd8 : 64'd0);
  assign last_addr   = f_pc + ilen - 64'd1;
  assign imem_error  = (f_pc >= MEM_LIMIT) || (last_addr >= MEM_LIMIT);

  assign f_icode     = imem_error ? INOP : raw_icode;
  assign f_ifun      = imem_error ? 4'h0 : ibyte[3:0];
  assign instr_valid = (f_icode <= IPOPQ);

  assign f_rA   = need_regids ? ibytes[7:4] : RNONE;
  assign f_rB   = need_regids ? ibytes[3:0] : RNONE;
  assign f_valC = need_regids ? ibytes[71:8] : ibytes[63:0];
  assign f_valP = f_pc + ilen;

  always_comb begin
    f_stat = SAOK;
    if (imem_error)          f_stat = SADR;
    else if (!instr_valid)   f_stat = SINS;
    else if (f_icode == IHALT) f_stat = SHLT;
  end

`ifdef FETCH_TRACE_EN
  always @(posedge clock) begin
    $display("fetch pc=%h icode=%h ifun=%h", f_pc, f_icode, f_ifun);
  end
`endif

endmodule

// File: tb/tb_y86_fetch_unit.sv
// Bench for y86_fetch_unit: directed encodings plus random memory images checked against a byte-array model.
module tb_y86_fetch_unit;

  localparam int MEM = 4096;
  localparam logic [63:0] MEML = 64'(MEM);

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_en = 1'b0;
  logic [63:0] load_addr = '0;
  logic [7:0]  load_data = '0;
  logic [63:0] f_pc = '0;
  logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
  logic [63:0] f_valC, f_valP;
  logic        need_regids, need_valC, instr_valid, imem_error;
  logic [2:0]  f_stat;

  int total = 0;
  int bad = 0;

  logic [7:0] mem_m [MEM];

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic        nr;
    logic        nc;
    logic        iv;
    logic        err;
    logic [2:0]  stat;
  } exp_t;

  always #5 clock = ~clock;

  y86_fetch_unit #(.MEM_BYTES(MEM)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .f_pc        (f_pc),
    .f_icode     (f_icode),
    .f_ifun      (f_ifun),
    .f_rA        (f_rA),
    .f_rB        (f_rB),
    .f_valC      (f_valC),
    .f_valP      (f_valP),
    .need_regids (need_regids),
    .need_valC   (need_valC),
    .instr_valid (instr_valid),
    .imem_error  (imem_error),
    .f_stat      (f_stat)
  );

  function automatic logic [7:0] rd(input logic [63:0] a);
    if (a < MEML) return mem_m[a[11:0]];
    return 8'h00;
  endfunction

  // Reference decode straight from the ISA tables: length, fields and status from a flat byte array.
  function automatic exp_t model(input logic [63:0] pc);
    exp_t e;
    logic [7:0] b0, b1;
    logic [3:0] ic;
    int len;
    b0 = rd(pc);
    ic = b0[7:4];
    e = '0;
    e.nr = (ic == 4'h2 || ic == 4'h3 || ic == 4'h4 || ic == 4'h5 || ic == 4'h6 || ic == 4'hA || ic == 4'hB);
    e.nc = (ic == 4'h3 || ic == 4'h4 || ic == 4'h5 || ic == 4'h7 || ic == 4'h8);
    len = 1 + (e.nr ? 1 : 0) + (e.nc ? 8 : 0);
    e.err = (pc >= MEML) || (pc + 64'(len) - 1 >= MEML);
    e.icode = e.err ? 4'h1 : ic;
    e.ifun = e.err ? 4'h0 : b0[3:0];
    b1 = rd(pc + 1);
    e.ra = e.nr ? b1[7:4] : 4'hF;
    e.rb = e.nr ? b1[3:0] : 4'hF;
    for (int i = 0; i < 8; i++)
      e.valc = e.valc | (64'(rd(pc + 1 + (e.nr ? 1 : 0) + 64'(i))) << (8 * i));
    e.valp = pc + 64'(len);
    e.iv = (e.icode <= 4'hB);
    e.stat = e.err ? 3'd3 : (!e.iv ? 3'd4 : (e.icode == 4'h0 ? 3'd2 : 3'd1));
    return e;
  endfunction

  task automatic load_byte(input logic [63:0] a, input logic [7:0] d);
    @(negedge clock);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clock);
    load_en = 1'b0;
    if (a < MEML) mem_m[a[11:0]] = d;
  endtask

  // v holds n bytes, first byte in the most significant of those n positions.
  task automatic load_bytes(input logic [63:0] a, input logic [79:0] v, input int n);
    for (int i = 0; i < n; i++) load_byte(a + 64'(i), v[8*(n-1-i) +: 8]);
  endtask

  task automatic test_reset;
    for (int i = 0; i < MEM; i++) mem_m[i] = 8'h00;
    reset_n = 1'b0; f_pc = 64'h0;
    #3;
    total++; if (f_icode !== 4'h0) begin bad++; $display("FAIL reset_icode got=%h want=0", f_icode); end
    total++; if (f_ifun !== 4'h0) begin bad++; $display("FAIL reset_ifun got=%h want=0", f_ifun); end
    total++; if (f_stat !== 3'd2) begin bad++; $display("FAIL reset_stat got=%0d want=2", f_stat); end
    total++; if (f_valP !== 64'd1) begin bad++; $display("FAIL reset_valP got=%h want=1", f_valP); end
    total++; if (f_rA !== 4'hF || f_rB !== 4'hF) begin bad++; $display("FAIL reset_regs got=%h%h want=FF", f_rA, f_rB); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_irmovq;
    load_bytes(64'h0, 80'h30F20A00000000000000, 10);
    f_pc = 64'h0; #1;
    total++; if (f_icode !== 4'h3) begin bad++; $display("FAIL irmovq_icode got=%h want=3", f_icode); end
    total++; if (f_rA !== 4'hF || f_rB !== 4'h2) begin bad++; $display("FAIL irmovq_regs got=%h%h want=F2", f_rA, f_rB); end
    total++; if (f_valC !== 64'd10) begin bad++; $display("FAIL irmovq_valC got=%h want=a", f_valC); end
    total++; if (f_valP !== 64'd10) begin bad++; $display("FAIL irmovq_valP got=%h want=a", f_valP); end
    total++; if (f_stat !== 3'd1) begin bad++; $display("FAIL irmovq_stat got=%0d want=1", f_stat); end
    total++; if (need_regids !== 1'b1 || need_valC !== 1'b1) begin bad++; $display("FAIL irmovq_need got=%b%b want=11", need_regids, need_valC); end
  endtask

  task automatic test_jxx;
    load_bytes(64'h14, 80'h702000000000000000, 9);
    f_pc = 64'h14; #1;
    total++; if (f_icode !== 4'h7) begin bad++; $display("FAIL jxx_icode got=%h want=7", f_icode); end
    total++; if (f_rA !== 4'hF || f_rB !== 4'hF) begin bad++; $display("FAIL jxx_regs got=%h%h want=FF", f_rA, f_rB); end
    total++; if (f_valC !== 64'h20) begin bad++; $display("FAIL jxx_valC got=%h want=20", f_valC); end
    total++; if (f_valP !== 64'h1D) begin bad++; $display("FAIL jxx_valP got=%h want=1d", f_valP); end
  endtask

  task automatic test_opq;
    load_bytes(64'h30, 80'h6023, 2);
    f_pc = 64'h30; #1;
    total++; if (f_icode !== 4'h6 || f_ifun !== 4'h0) begin bad++; $display("FAIL opq_code got=%h%h want=60", f_icode, f_ifun); end
    total++; if (f_rA !== 4'h2 || f_rB !== 4'h3) begin bad++; $display("FAIL opq_regs got=%h%h want=23", f_rA, f_rB); end
    total++; if (f_valP !== 64'h32) begin bad++; $display("FAIL opq_valP got=%h want=32", f_valP); end
  endtask

  task automatic test_invalid;
    load_byte(64'h40, 8'hC0);
    f_pc = 64'h40; #1;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL ins_valid got=%b want=0", instr_valid); end
    total++; if (f_stat !== 3'd4) begin bad++; $display("FAIL ins_stat got=%0d want=4", f_stat); end
    total++; if (f_valP !== 64'h41) begin bad++; $display("FAIL ins_valP got=%h want=41", f_valP); end
  endtask

  task automatic test_mem_edge;
    load_bytes(MEML - 2, 80'h30F2, 2);
    f_pc = MEML - 2; #1;
    total++; if (imem_error !== 1'b1) begin bad++; $display("FAIL edge_err got=%b want=1", imem_error); end
    total++; if (f_icode !== 4'h1 || f_ifun !== 4'h0) begin bad++; $display("FAIL edge_code got=%h%h want=10", f_icode, f_ifun); end
    total++; if (f_stat !== 3'd3) begin bad++; $display("FAIL edge_stat got=%0d want=3", f_stat); end
    // Single-byte opcode in the last byte is in range.
    f_pc = MEML - 1; #1;
    total++; if (imem_error !== 1'b0 || f_stat !== 3'd4) begin bad++; $display("FAIL last_byte got=%b/%0d want=0/4", imem_error, f_stat); end
    // Two-byte instruction ending exactly at the last byte is in range.
    load_byte(MEML - 2, 8'h60);
    f_pc = MEML - 2; #1;
    total++; if (imem_error !== 1'b0 || f_stat !== 3'd1) begin bad++; $display("FAIL fit_end got=%b/%0d want=0/1", imem_error, f_stat); end
    total++; if (f_rB !== 4'h2 || f_valP !== MEML) begin bad++; $display("FAIL fit_end_fields got=%h/%h want=2/%h", f_rB, f_valP, MEML); end
    f_pc = MEML; #1;
    total++; if (imem_error !== 1'b1 || f_stat !== 3'd3) begin bad++; $display("FAIL pc_oob got=%b/%0d want=1/3", imem_error, f_stat); end
    total++; if (f_icode !== 4'h1) begin bad++; $display("FAIL pc_oob_icode got=%h want=1", f_icode); end
  endtask

  task automatic test_oob_write;
    load_byte(MEML + 64'h50, 8'h30);
    f_pc = 64'h50; #1;
    total++; if (f_icode !== 4'h0 || f_stat !== 3'd2) begin bad++; $display("FAIL oob_write got=%h/%0d want=0/2", f_icode, f_stat); end
  endtask

  task automatic test_write_visible;
    @(negedge clock);
    f_pc = 64'h60; load_en = 1'b1; load_addr = 64'h60; load_data = 8'h10;
    #1;
    total++; if (f_icode !== 4'h0) begin bad++; $display("FAIL pre_edge got=%h want=0", f_icode); end
    @(posedge clock); #1;
    total++; if (f_icode !== 4'h1 || f_stat !== 3'd1) begin bad++; $display("FAIL post_edge got=%h/%0d want=1/1", f_icode, f_stat); end
    load_en = 1'b0;
    mem_m[12'h60] = 8'h10;
  endtask

  task automatic test_random;
    exp_t e;
    logic [63:0] a;
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 2))
        0: a = 64'h80 + 64'($urandom_range(0, 31));
        1: a = MEML - 16 + 64'($urandom_range(0, 15));
        default: a = MEML + 64'($urandom_range(0, 15));
      endcase
      load_byte(a, 8'($urandom));
      case ($urandom_range(0, 3))
        0, 1: f_pc = 64'h80 + 64'($urandom_range(0, 31));
        2: f_pc = MEML - 12 + 64'($urandom_range(0, 11));
        default: f_pc = MEML + 64'($urandom_range(0, 3));
      endcase
      #1;
      e = model(f_pc);
      total++; if (imem_error !== e.err || f_stat !== e.stat) begin bad++; $display("FAIL rnd_stat pc=%h got=%b/%0d want=%b/%0d", f_pc, imem_error, f_stat, e.err, e.stat); end
      total++; if (f_icode !== e.icode || f_ifun !== e.ifun) begin bad++; $display("FAIL rnd_code pc=%h got=%h%h want=%h%h", f_pc, f_icode, f_ifun, e.icode, e.ifun); end
      if (!e.err) begin
        total++; if (f_rA !== e.ra || f_rB !== e.rb) begin bad++; $display("FAIL rnd_regs pc=%h got=%h%h want=%h%h", f_pc, f_rA, f_rB, e.ra, e.rb); end
        total++; if (f_valC !== e.valc) begin bad++; $display("FAIL rnd_valC pc=%h got=%h want=%h", f_pc, f_valC, e.valc); end
        total++; if (f_valP !== e.valp) begin bad++; $display("FAIL rnd_valP pc=%h got=%h want=%h", f_pc, f_valP, e.valp); end
        total++; if (need_regids !== e.nr || need_valC !== e.nc || instr_valid !== e.iv) begin bad++; $display("FAIL rnd_flags pc=%h got=%b%b%b want=%b%b%b", f_pc, need_regids, need_valC, instr_valid, e.nr, e.nc, e.iv); end
      end
    end
  endtask

  task automatic test_reset_clears;
    @(negedge clock);
    reset_n = 1'b0;
    for (int i = 0; i < MEM; i++) mem_m[i] = 8'h00;
    f_pc = 64'h14; #1;
    total++; if (f_icode !== 4'h0 || f_stat !== 3'd2 || f_valP !== 64'h15) begin bad++; $display("FAIL rst_clear got=%h/%0d/%h want=0/2/15", f_icode, f_stat, f_valP); end
    @(negedge clock);
    reset_n = 1'b1;
    f_pc = 64'h0; #1;
    total++; if (f_icode !== 4'h0 || f_valP !== 64'h1) begin bad++; $display("FAIL rst_clear0 got=%h/%h want=0/1", f_icode, f_valP); end
  endtask

  initial begin
    test_reset;
    test_irmovq;
    test_jxx;
    test_opq;
    test_invalid;
    test_mem_edge;
    test_oob_write;
    test_write_visible;
    test_random;
    test_reset_clears;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
